// File: rtl/led_seq_cpu.sv
// Programmable LED sequencer.
// A debounced switch/enter loader writes instructions into an internal 1R1W RAM.
// A small sequencer core fetches and executes them and drives outPattern on a divided tick.
// Instruction word = {op[1:0], cnt[5:0], pat[LED_W-1:0]}.
// ops: 00 SHOW, 01 JUMP, 10 HALT, 11 BLINK.
// Optional feature: define LEDCPU_STEP_EN to advance SHOW/BLINK ticks on debounced enter
// presses instead of every FREQ clock cycles.
module led_seq_cpu #(
    parameter int LED_W  = 8,
    parameter int ADDR_W = 8,
    parameter int NDELAY = 1000,
    parameter int FREQ   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LED_W-1:0]  switch,
    input  logic              enter,
    input  logic              mode,
    output logic [LED_W-1:0]  outPattern,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    localparam int IW    = LED_W + 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DW    = (NDELAY > 1) ? $clog2(NDELAY + 1) : 1;
    localparam int TW    = (FREQ > 1) ? $clog2(FREQ) : 1;

    localparam logic [1:0] OP_SHOW  = 2'b00;
    localparam logic [1:0] OP_JUMP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_BLINK = 2'b11;

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_t;

    // Debounce / edge detect
    logic          enter_s;
    logic          deb;
    logic [DW-1:0] db_cnt;
    logic          press;

    // Mode tracking
    logic mode_q;
    logic mode_rise;
    logic mode_fall;
    logic press_ok;

    // Loader
    logic [ADDR_W-1:0] wptr;
    logic              phase;
    logic [LED_W-1:0]  pat_lat;
    logic              we;
    logic [IW-1:0]     wdata;

    // Program RAM
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] rdata;

    // Sequencer
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [LED_W-1:0]  out_d;
    logic [1:0]        ir_op_q, ir_op_d;
    logic [LED_W-1:0]  ir_pat_q, ir_pat_d;
    logic [5:0]        left_q, left_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;

    logic [1:0]       r_op;
    logic [5:0]       r_cnt;
    logic [LED_W-1:0] r_pat;

    assign r_op  = rdata[IW-1:IW-2];
    assign r_cnt = rdata[IW-3:LED_W];
    assign r_pat = rdata[LED_W-1:0];

    // Synchronise enter, require NDELAY stable cycles, pulse on debounced rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_s <= 1'b0;
            deb     <= 1'b0;
            db_cnt  <= '0;
            press   <= 1'b0;
        end else begin
            enter_s <= enter;
            press   <= 1'b0;
            if (enter_s != deb) begin
                if (db_cnt == DW'(NDELAY - 1)) begin
                    deb    <= enter_s;
                    db_cnt <= '0;
                    press  <= enter_s;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // mode_q resets to run so that a mode held high through reset does not restart the program
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= 1'b1;
        else     mode_q <= mode;
    end

    assign mode_rise = mode & ~mode_q;
    assign mode_fall = ~mode & mode_q;
    assign press_ok  = press & (mode == mode_q);

    assign we    = ~mode & press_ok & phase;
    assign wdata = {switch[7:0], pat_lat};

    // Two-press loader: first press latches the pattern, second writes the full word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            phase   <= 1'b0;
            pat_lat <= '0;
        end else if (mode_fall) begin
            wptr  <= '0;
            phase <= 1'b0;
        end else if (!mode && press_ok) begin
            if (!phase) begin
                pat_lat <= switch;
                phase   <= 1'b1;
            end else begin
                phase <= 1'b0;
                wptr  <= wptr + ADDR_W'(1);
            end
        end
    end

    // Program RAM: registered read returns old data on a same-address write
    always_ff @(posedge clk) begin
        if (we) mem[wptr] <= wdata;
        rdata <= mem[pc];
    end

`ifdef LEDCPU_STEP_EN
    assign tick = press_ok & mode;
`else
    assign tick = (tick_cnt_q == TW'(FREQ - 1));
`endif

    // Sequencer state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc         <= '0;
            outPattern <= '0;
            ir_op_q    <= OP_SHOW;
            ir_pat_q   <= '0;
            left_q     <= '0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            outPattern <= out_d;
            ir_op_q    <= ir_op_d;
            ir_pat_q   <= ir_pat_d;
            left_q     <= left_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        out_d      = outPattern;
        ir_op_d    = ir_op_q;
        ir_pat_d   = ir_pat_q;
        left_d     = left_q;
        tick_cnt_d = tick_cnt_q;
        if (!mode) begin
            state_d = StIdle;
            if (mode_fall) pc_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mode_rise) begin
                        state_d = StFetch;
                        pc_d    = '0;
                    end
                end
                StFetch: state_d = StDecode;
                StDecode: begin
                    ir_op_d  = r_op;
                    ir_pat_d = r_pat;
                    unique case (r_op)
                        OP_SHOW: begin
                            out_d      = r_pat;
                            left_d     = r_cnt;
                            tick_cnt_d = '0;
                            state_d    = StExec;
                        end
                        OP_JUMP: begin
                            pc_d    = r_pat[ADDR_W-1:0];
                            state_d = StFetch;
                        end
                        OP_HALT: begin
                            out_d   = r_pat;
                            state_d = StHalt;
                        end
                        OP_BLINK: begin
                            left_d     = r_cnt;
                            tick_cnt_d = '0;
                            state_d    = StExec;
                        end
                        default: state_d = StIdle;
                    endcase
                end
                StExec: begin
                    tick_cnt_d = (tick_cnt_q == TW'(FREQ - 1)) ? '0 : tick_cnt_q + TW'(1);
                    if (tick) begin
                        if (ir_op_q == OP_BLINK) out_d = outPattern ^ ir_pat_q;
                        if (left_q == 6'd0) begin
                            pc_d    = pc + ADDR_W'(1);
                            state_d = StFetch;
                        end else begin
                            left_d = left_q - 6'd1;
                        end
                    end
                end
                StHalt: state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);

endmodule

// File: tb/tb_led_seq_cpu.sv
// Directed self-checking bench for led_seq_cpu (LED_W=8, ADDR_W=4, NDELAY=4, FREQ=8).
// Define LEDCPU_STEP_EN on both RTL and bench to exercise the single-step build.
`timescale 1ns/1ps
module tb_led_seq_cpu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] switch;
    logic       enter;
    logic       mode;
    logic [7:0] outPattern;
    logic [3:0] pc;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    led_seq_cpu #(
        .LED_W (8),
        .ADDR_W(4),
        .NDELAY(4),
        .FREQ  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch    (switch),
        .enter     (enter),
        .mode      (mode),
        .outPattern(outPattern),
        .pc        (pc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        switch = v;
        enter  = 1'b1;
        repeat (8) @(negedge clk);
        enter = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] hi, input logic [7:0] lo);
        press(lo);
        press(hi);
    endtask

    task automatic to_program;
        @(negedge clk);
        mode = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic to_run;
        @(negedge clk);
        mode = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; switch = '0; enter = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outPattern !== 8'h00 || pc !== 4'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got out=%h pc=%h busy=%b expected 00/0/0",
                     outPattern, pc, busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // SHOW A5 for 3 ticks then HALT 3C
    task automatic test_show_halt;
        int  a5 = 0;
        bit  seen = 0;
        logic mid_busy = 1'b0;
        to_program;
        load(8'h02, 8'hA5);
        load(8'h80, 8'h3C);
        to_run;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (i == 10) mid_busy = busy;
            if (outPattern === 8'hA5) a5++;
            if (outPattern === 8'h3C) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL show_halt_timeout: got out=%h expected 3c", outPattern);
        end
        checks++;
        if (mid_busy !== 1'b1) begin
            failures++;
            $display("FAIL show_busy: got %b expected 1", mid_busy);
        end
        // 3 ticks x 8 clk, plus fetch/decode of the HALT word
        checks++;
        if (a5 < 24 || a5 > 26) begin
            failures++;
            $display("FAIL show_hold_cycles: got %0d expected 24..26", a5);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (outPattern !== 8'h3C || busy !== 1'b0 || pc !== 4'h1) begin
            failures++;
            $display("FAIL halt_state: got out=%h busy=%b pc=%h expected 3c/0/1",
                     outPattern, busy, pc);
        end
    endtask

    // SHOW 01 cnt=0 then JUMP 0: pc loops 0,1,0 and pattern holds
    task automatic test_jump;
        int   back = 0;
        bit   bad  = 0;
        logic [3:0] prev;
        to_program;
        load(8'h00, 8'h01);
        load(8'h40, 8'h00);
        to_run;
        prev = pc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prev === 4'h1 && pc === 4'h0) back++;
            prev = pc;
            if (i > 5 && outPattern !== 8'h01) bad = 1;
            if (busy !== 1'b1) bad = 1;
            if (pc !== 4'h0 && pc !== 4'h1) bad = 1;
        end
        checks++;
        if (back < 2) begin
            failures++;
            $display("FAIL jump_loops: got %0d expected >=2", back);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL jump_hold: got out=%h pc=%h busy=%b expected 01, pc in {0,1}, busy 1",
                     outPattern, pc, busy);
        end
    endtask

    // Async reset mid-run clears outputs immediately and holds until mode toggles
    task automatic test_reset_midrun;
        to_program;
        load(8'h00, 8'h01);
        load(8'h40, 8'h00);
        to_run;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outPattern !== 8'h00 || pc !== 4'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset_async: got out=%h pc=%h busy=%b expected 00/0/0",
                     outPattern, pc, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (outPattern !== 8'h00 || pc !== 4'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset_hold: got out=%h pc=%h busy=%b expected 00/0/0",
                     outPattern, pc, busy);
        end
        to_program;
        to_run;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || outPattern !== 8'h01) begin
            failures++;
            $display("FAIL midrun_restart: got busy=%b out=%h expected 1/01", busy, outPattern);
        end
    endtask

    // SHOW 0F, BLINK FF x4, HALT AA
    task automatic test_blink;
        logic [7:0] seq[$];
        int         ts[$];
        logic [7:0] exp_seq [6];
        logic [7:0] prev;
        exp_seq = '{8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hAA};
        to_program;
        load(8'h00, 8'h0F);
        load(8'hC3, 8'hFF);
        load(8'h80, 8'hAA);
        to_run;
        prev = outPattern;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (outPattern !== prev) begin
                seq.push_back(outPattern);
                ts.push_back(i);
            end
            prev = outPattern;
            if (i > 3 && busy === 1'b0) break;
        end
        checks++;
        if (seq.size() != 6) begin
            failures++;
            $display("FAIL blink_count: got %0d changes expected 6", seq.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= seq.size()) begin
                failures++;
                $display("FAIL blink_seq[%0d]: got none expected %h", k, exp_seq[k]);
            end else if (seq[k] !== exp_seq[k]) begin
                failures++;
                $display("FAIL blink_seq[%0d]: got %h expected %h", k, seq[k], exp_seq[k]);
            end
        end
        checks++;
        if (ts.size() < 3) begin
            failures++;
            $display("FAIL blink_period: got too few changes expected 8 cycles");
        end else if (ts[2] - ts[1] != 8) begin
            failures++;
            $display("FAIL blink_period: got %0d expected 8", ts[2] - ts[1]);
        end
    endtask

    // 17 writes wrap to address 0; short enter glitch must not count as a press
    task automatic test_wrap_glitch;
        bit ok = 0;
        to_program;
        for (int i = 0; i < 16; i++) begin
            load(8'h80, (i == 0) ? 8'h11 : 8'(i));
        end
        load(8'h80, 8'h77);
        to_run;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1;
        end
        checks++;
        if (!ok || outPattern !== 8'h77 || pc !== 4'h0) begin
            failures++;
            $display("FAIL wrap_overwrite: got out=%h pc=%h busy=%b expected 77/0/0",
                     outPattern, pc, busy);
        end
        to_program;
        press(8'h42);
        @(negedge clk);
        switch = 8'h00;
        enter  = 1'b1;
        repeat (2) @(negedge clk);
        enter = 1'b0;
        repeat (8) @(negedge clk);
        press(8'h80);
        to_run;
        repeat (30) @(negedge clk);
        checks++;
        if (outPattern !== 8'h42 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_ignored: got out=%h busy=%b expected 42/0", outPattern, busy);
        end
    endtask

`ifdef LEDCPU_STEP_EN
    // SHOW cnt=1 needs two enter presses before pc advances to the HALT
    task automatic test_step;
        to_program;
        load(8'h01, 8'h5A);
        load(8'h80, 8'h99);
        to_run;
        repeat (20) @(negedge clk);
        checks++;
        if (pc !== 4'h0 || busy !== 1'b1 || outPattern !== 8'h5A) begin
            failures++;
            $display("FAIL step_wait: got pc=%h busy=%b out=%h expected 0/1/5a",
                     pc, busy, outPattern);
        end
        press(8'h00);
        checks++;
        if (pc !== 4'h0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL step_one_press: got pc=%h busy=%b expected 0/1", pc, busy);
        end
        press(8'h00);
        checks++;
        if (pc !== 4'h1 || busy !== 1'b0 || outPattern !== 8'h99) begin
            failures++;
            $display("FAIL step_two_press: got pc=%h busy=%b out=%h expected 1/0/99",
                     pc, busy, outPattern);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifndef LEDCPU_STEP_EN
        test_show_halt;
        test_jump;
`endif
        test_reset_midrun;
`ifndef LEDCPU_STEP_EN
        test_blink;
`endif
        test_wrap_glitch;
`ifdef LEDCPU_STEP_EN
        test_step;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
